// File: rtl/arc4_pkg.sv
// Shared constants for the ARC4 S-box checking blocks.
package arc4_pkg;

    localparam int unsigned S_DEPTH = 256;

    localparam logic MODE_IDENTITY = 1'b0;
    localparam logic MODE_PERM     = 1'b1;

endpackage

// File: rtl/s_check_if.sv
// Bundle of the start/result handshake and the S-memory read port of s_check.
interface s_check_if;

    logic       en;
    logic       rdy;
    logic       mode;
    logic [7:0] addr;
    logic [7:0] rddata;
    logic       pass;
    logic [8:0] err_count;
    logic [7:0] first_bad;

    // Requester side: starts runs, owns the S memory, reads results.
    modport master (
        output en,
        output mode,
        output rddata,
        input  rdy,
        input  addr,
        input  pass,
        input  err_count,
        input  first_bad
    );

    // Checker side.
    modport slave (
        input  en,
        input  mode,
        input  rddata,
        output rdy,
        output addr,
        output pass,
        output err_count,
        output first_bad
    );

endinterface

// File: rtl/s_check.sv
// S-box checker: walks all 256 entries of S, checks identity or
// permutation, and reports pass, mismatch count and first bad index.
module s_check
    import arc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    input  logic       mode,
    output logic [7:0] addr,
    input  logic [7:0] rddata,
    output logic       pass,
    output logic [8:0] err_count,
    output logic [7:0] first_bad
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WAIT   = 3'd2,
        CHECK  = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          i_q, i_d;
    logic                mode_q, mode_d;
    logic                pass_q, pass_d;
    logic [8:0]          err_count_q, err_count_d;
    logic [7:0]          first_bad_q, first_bad_d;
    logic [S_DEPTH-1:0]  seen_q, seen_d;
    logic                mismatch;

    // The read address is the index itself: it is loaded on entry to READ,
    // stays put through WAIT/CHECK and never wraps, so it holds 255 after a run.
    assign addr      = i_q;
    assign rdy       = (state_q == IDLE);
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign first_bad = first_bad_q;

    // Mismatch decision for the entry returned by the memory this cycle.
    always_comb begin
        mismatch = 1'b0;
        if (mode_q == MODE_PERM) begin
            mismatch = seen_q[rddata];
        end else begin
            mismatch = (rddata != i_q);
        end
    end

    // Next-state and datapath update for the scan FSM.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        mode_d      = mode_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        first_bad_d = first_bad_q;
        seen_d      = seen_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    mode_d      = mode;
                    i_d         = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
                    first_bad_d = '0;
                    seen_d      = '0;
                    state_d     = READ;
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (mismatch) begin
                    err_count_d = err_count_q + 9'd1;
                    if (err_count_q == '0) begin
                        first_bad_d = i_q;
                    end
                end
                if (mode_q == MODE_PERM) begin
                    seen_d[rddata] = 1'b1;
                end
                if (i_q == 8'd255) begin
                    state_d = FINISH;
                end else begin
                    i_d     = i_q + 8'd1;
                    state_d = READ;
                end
            end
            FINISH: begin
                pass_d  = (err_count_q == '0);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            i_q         <= '0;
            mode_q      <= MODE_IDENTITY;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            first_bad_q <= '0;
            seen_q      <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            mode_q      <= mode_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            first_bad_q <= first_bad_d;
            seen_q      <= seen_d;
        end
    end

endmodule

// File: tb/tb_s_check.sv
// Scoreboard bench for s_check: the stimulus pushes model results, a monitor
// pops them when rdy returns, and also checks address stepping and idle hold.
module tb_s_check;
    import arc4_pkg::*;

    typedef struct {
        logic       pass;
        logic [8:0] errs;
        logic [7:0] fb;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    s_check_if bus ();

    s_check dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (bus.en),
        .rdy       (bus.rdy),
        .mode      (bus.mode),
        .addr      (bus.addr),
        .rddata    (bus.rddata),
        .pass      (bus.pass),
        .err_count (bus.err_count),
        .first_bad (bus.first_bad)
    );

    // S memory: registered read, data valid one cycle after addr.
    logic [7:0] mem [S_DEPTH];
    logic [7:0] rd_reg;
    logic [7:0] junk = 8'h00;
    logic       poison = 1'b0;
    always @(posedge clk) rd_reg <= mem[bus.addr];
    // Outside the CHECK cycle the read data is scrambled.
    assign bus.rddata = poison ? junk : rd_reg;

    res_t   exp_q[$];
    int     compared   = 0;
    int     mismatched = 0;

    bit     busy       = 1'b0;
    int     ecount     = 0;
    int     runs_started = 0;
    int     runs_done  = 0;
    bit     rst_seen   = 1'b0;
    longint cyc        = 0;
    longint accept_cyc[$];
    res_t   last       = '{1'b0, 9'd0, 8'd0};
    logic [7:0] idle_addr = 8'd0;

    function automatic void check(input string name, input longint act, input longint req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void timeout(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endfunction

    // Edge tracker: detects accepted starts and resets, counts cycles into a run.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            if (busy && exp_q.size() > 0) void'(exp_q.pop_front());
            busy     = 1'b0;
            rst_seen = 1'b1;
        end else if (!busy && bus.rdy && bus.en) begin
            busy   = 1'b1;
            ecount = 0;
            runs_started++;
            accept_cyc.push_back(cyc);
        end else if (busy) begin
            ecount++;
        end
    end

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        junk = 8'($urandom);
        if (rst_seen) begin
            rst_seen = 1'b0;
            check("rst_rdy", bus.rdy, 1);
            check("rst_pass", bus.pass, 0);
            check("rst_err", bus.err_count, 0);
            check("rst_first_bad", bus.first_bad, 0);
            check("rst_addr", bus.addr, 0);
            last      = '{1'b0, 9'd0, 8'd0};
            idle_addr = 8'd0;
        end else if (busy) begin
            if (ecount < 768) begin
                check("addr_step", bus.addr, ecount / 3);
                check("busy_rdy", bus.rdy, 0);
            end else if (ecount == 768) begin
                check("finish_rdy", bus.rdy, 0);
                check("finish_addr", bus.addr, 255);
            end else begin
                check("done_rdy_769", bus.rdy, 1);
                check("done_addr", bus.addr, 255);
                if (exp_q.size() == 0) begin
                    timeout("scoreboard_empty");
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("pass", bus.pass, e.pass);
                    check("err_count", bus.err_count, e.errs);
                    check("first_bad", bus.first_bad, e.fb);
                    last = e;
                end
                idle_addr = 8'd255;
                busy      = 1'b0;
                runs_done++;
            end
        end else begin
            check("idle_rdy", bus.rdy, 1);
            check("idle_pass", bus.pass, last.pass);
            check("idle_err", bus.err_count, last.errs);
            check("idle_first_bad", bus.first_bad, last.fb);
            check("idle_addr", bus.addr, idle_addr);
        end
        poison = busy && (ecount % 3 != 2);
    end

    // Reference model: scan the table in index order; in permutation mode an
    // entry is bad when its value already occurred at a lower index.
    task automatic model_push(input logic m);
        int   occ[S_DEPTH];
        int   errs;
        int   fb;
        bit   bad;
        errs = 0;
        fb   = 0;
        for (int k = 0; k < S_DEPTH; k++) occ[k] = 0;
        for (int k = 0; k < S_DEPTH; k++) begin
            if (m == MODE_PERM) bad = (occ[mem[k]] > 0);
            else                bad = (int'(mem[k]) != k);
            occ[mem[k]]++;
            if (bad) begin
                if (errs == 0) fb = k;
                errs++;
            end
        end
        exp_q.push_back('{errs == 0, 9'(errs), 8'(fb)});
    endtask

    task automatic wait_started(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (runs_started < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (runs_started < target) timeout(name);
    endtask

    task automatic wait_done(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (runs_done < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (runs_done < target) timeout(name);
    endtask

    task automatic run(input logic m, input bit noise);
        int s;
        int d;
        int n;
        s = runs_started;
        d = runs_done;
        model_push(m);
        bus.mode = m;
        bus.en   = 1'b1;
        wait_started(s + 1, 10, "start");
        bus.mode = 1'($urandom);
        bus.en   = 1'b0;
        if (noise) begin
            n = 0;
            while (busy && ecount < 700 && n < 800) begin
                bus.en   = 1'($urandom);
                bus.mode = 1'($urandom);
                @(negedge clk);
                n++;
            end
            bus.en = 1'b0;
        end
        wait_done(d + 1, 1000, "run_done");
    endtask

    task automatic fill_identity();
        for (int k = 0; k < S_DEPTH; k++) mem[k] = 8'(k);
    endtask

    task automatic fill_reverse();
        for (int k = 0; k < S_DEPTH; k++) mem[k] = 8'(255 - k);
    endtask

    task automatic fill_shuffle();
        logic [7:0] t;
        int         j;
        fill_identity();
        for (int k = S_DEPTH - 1; k > 0; k--) begin
            j      = int'($urandom_range(k, 0));
            t      = mem[k];
            mem[k] = mem[j];
            mem[j] = t;
        end
    endtask

    initial begin
        int s;
        int d;
        int n;
        bus.en   = 1'b0;
        bus.mode = 1'b0;
        for (int k = 0; k < S_DEPTH; k++) mem[k] = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Identity pass, identity fail, reversed table in both modes.
        fill_identity();
        run(MODE_IDENTITY, 1'b0);
        mem[8'h10] = 8'hAA;
        mem[8'hF0] = 8'h00;
        run(MODE_IDENTITY, 1'b0);
        fill_reverse();
        run(MODE_PERM, 1'b0);
        run(MODE_IDENTITY, 1'b0);

        // Duplicate value in permutation mode.
        mem[8'h80] = 8'h80;
        mem[8'h7F] = 8'h80;
        run(MODE_PERM, 1'b0);

        // en held high: back-to-back runs with one idle cycle between them.
        fill_identity();
        s = runs_started;
        d = runs_done;
        model_push(MODE_IDENTITY);
        model_push(MODE_IDENTITY);
        bus.mode = MODE_IDENTITY;
        bus.en   = 1'b1;
        wait_started(s + 2, 2000, "held_en_second_start");
        bus.en = 1'b0;
        wait_done(d + 2, 1000, "held_en_done");
        if (accept_cyc.size() >= 2)
            check("restart_gap", accept_cyc[accept_cyc.size() - 1] - accept_cyc[accept_cyc.size() - 2], 770);
        check("held_en_runs", runs_started - s, 2);

        // Reset 300 cycles into a run aborts it.
        fill_shuffle();
        s = runs_started;
        model_push(MODE_PERM);
        bus.mode = MODE_PERM;
        bus.en   = 1'b1;
        wait_started(s + 1, 10, "rst_run_start");
        bus.en = 1'b0;
        n = 0;
        while (!(busy && ecount == 300) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!(busy && ecount == 300)) timeout("rst_point");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_dropped", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        // Randomized tables, random mode, en/mode noise during the run.
        for (int r = 0; r < 8; r++) begin
            case ($urandom % 3)
                0: begin
                    fill_shuffle();
                    for (int c = 0; c < int'($urandom % 4); c++)
                        mem[$urandom % S_DEPTH] = 8'($urandom);
                end
                1: begin
                    fill_identity();
                    for (int c = 0; c < int'($urandom % 5); c++)
                        mem[$urandom % S_DEPTH] = 8'($urandom);
                end
                default: begin
                    for (int k = 0; k < S_DEPTH; k++) mem[k] = 8'($urandom);
                end
            endcase
            run(1'($urandom), 1'b1);
            repeat (int'($urandom % 4)) @(negedge clk);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
